// File: rtl/shifter_pkg.sv
// Shared types and helpers for the pipelined barrel shifter.
package shifter_pkg;

    typedef enum logic [1:0] {
        SRL = 2'b00,
        SRA = 2'b01,
        SLL = 2'b10,
        ROR = 2'b11
    } shift_op_t;

    // Number of shift levels per register stage (last stage takes the remainder).
    function automatic int unsigned levels_per_stage(input int unsigned s, input int unsigned p);
        return (s + p - 1) / p;
    endfunction

endpackage

// File: rtl/barrel_shift_level.sv
// One combinational level of the barrel shifter: shifts by D when enabled and
// reports whether any discarded bit was set. Rotate logic only exists when
// SHIFTER_ROTATE_EN is defined.
module barrel_shift_level
    import shifter_pkg::*;
#(
    parameter int unsigned N = 32,
    parameter int unsigned D = 1
) (
    input  logic [N-1:0] data,
    input  logic         en,
    input  shift_op_t    op,
    input  logic         fill,
    output logic [N-1:0] shifted,
    output logic         lost
);

    logic [N-1:0] right_c;
    logic [N-1:0] left_c;
    logic         right_lost;
    logic         left_lost;

    // A distance of N or more pushes the whole word out.
    if (D >= N) begin : g_all
        assign right_c    = {N{fill}};
        assign left_c     = {N{fill}};
        assign right_lost = |data;
        assign left_lost  = |data;
    end else begin : g_part
        assign right_c    = {{D{fill}}, data[N-1:D]};
        assign right_lost = |data[D-1:0];
        assign left_c     = {data[N-1-D:0], {D{fill}}};
        assign left_lost  = |data[N-1:N-D];
    end

`ifdef SHIFTER_ROTATE_EN
    logic [N-1:0] rot_c;

    if (D >= N) begin : g_rot_all
        assign rot_c = data;
    end else begin : g_rot_part
        assign rot_c = {data[D-1:0], data[N-1:D]};
    end
`endif

    // Select the shifted word and discarded-bit flag for this level.
    always_comb begin
        shifted = data;
        lost    = 1'b0;
        if (en) begin
            case (op)
                SLL: begin
                    shifted = left_c;
                    lost    = left_lost;
                end
`ifdef SHIFTER_ROTATE_EN
                ROR: begin
                    shifted = rot_c;
                    lost    = 1'b0;
                end
`endif
                default: begin
                    shifted = right_c;
                    lost    = right_lost;
                end
            endcase
        end
    end

endmodule

// File: rtl/barrel_shifter_pipe.sv
// Pipelined barrel shifter (SRL/SRA/SLL, optional ROR) with sticky output and
// valid/ready handshake. Define SHIFTER_ROTATE_EN to enable rotate (needs N = 2**S).
module barrel_shifter_pipe
    import shifter_pkg::*;
#(
    parameter int unsigned N           = 32,
    parameter int unsigned S           = 5,
    parameter int unsigned PIPE_STAGES = 2
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         flush,
    input  logic         valid_in,
    output logic         ready_in,
    input  logic [N-1:0] data_in,
    input  logic [S-1:0] amount,
    input  shift_op_t    op,
    output logic         valid_out,
    input  logic         ready_out,
    output logic [N-1:0] data_out,
    output logic         sticky_out
);

    localparam int unsigned P = PIPE_STAGES;
    localparam int unsigned L = levels_per_stage(S, PIPE_STAGES);

    if (P < 1 || P > S) begin : g_bad_stages
        $error("PIPE_STAGES must be in 1..S");
    end

`ifdef SHIFTER_ROTATE_EN
    if (N != 2 ** S) begin : g_bad_rotate
        $error("rotate requires N == 2**S");
    end
`endif

    shift_op_t    op_in;
    logic         hold_in;
    logic         sticky_in;

    logic [N-1:0] src_data   [P];
    logic         src_sticky [P];
    logic [S-1:0] src_amt    [P];
    shift_op_t    src_op     [P];
    logic         src_hold   [P];
    logic [N-1:0] nx_data    [P];
    logic         nx_sticky  [P];

    logic [N-1:0] st_data    [P];
    logic         st_sticky  [P];
    logic [S-1:0] st_amt     [P];
    shift_op_t    st_op      [P];
    logic         st_hold    [P];

    logic [P-1:0] st_valid;
    logic [P-1:0] valid_src;
    logic [P-1:0] can_load;

`ifdef SHIFTER_ROTATE_EN
    assign op_in = op;
`else
    assign op_in = (op == ROR) ? SRL : op;
`endif

    // SRA past the word width: sticky is every non-sign bit, so freeze it up front
    // rather than letting levels count shifted-in sign copies.
    assign hold_in   = (32'(amount) >= 32'(N)) && (op_in == SRA);
    assign sticky_in = hold_in & (|data_in[N-2:0]);

    for (genvar g = 0; g < int'(P); g++) begin : g_stage
        localparam int unsigned LO  = 32'(g) * L;
        localparam int unsigned HI  = (LO + L > S) ? S : LO + L;
        localparam int unsigned CNT = (HI > LO) ? HI - LO : 0;

        if (g == 0) begin : g_src_in
            assign src_data[g]   = data_in;
            assign src_sticky[g] = sticky_in;
            assign src_amt[g]    = amount;
            assign src_op[g]     = op_in;
            assign src_hold[g]   = hold_in;
            assign valid_src[g]  = valid_in;
        end else begin : g_src_reg
            assign src_data[g]   = st_data[g-1];
            assign src_sticky[g] = st_sticky[g-1];
            assign src_amt[g]    = st_amt[g-1];
            assign src_op[g]     = st_op[g-1];
            assign src_hold[g]   = st_hold[g-1];
            assign valid_src[g]  = st_valid[g-1];
        end

        // A stage can load when it, or every full stage after it, drains this cycle.
        assign can_load[g] = ready_out | ~(&st_valid[P-1:g]);

        for (genvar k = 0; k < int'(CNT); k++) begin : g_lvl
            logic [N-1:0] din;
            logic [N-1:0] sh;
            logic         sin;
            logic         sout;
            logic         lost;

            if (k == 0) begin : g_first
                assign din = src_data[g];
                assign sin = src_sticky[g];
            end else begin : g_next
                assign din = g_lvl[k-1].sh;
                assign sin = g_lvl[k-1].sout;
            end

            barrel_shift_level #(
                .N (N),
                .D (2 ** (LO + 32'(k)))
            ) u_level (
                .data    (din),
                .en      (src_amt[g][LO + 32'(k)]),
                .op      (src_op[g]),
                .fill    ((src_op[g] == SRA) & din[N-1]),
                .shifted (sh),
                .lost    (lost)
            );

            assign sout = sin | (lost & ~src_hold[g]);
        end

        if (CNT == 0) begin : g_pass
            assign nx_data[g]   = src_data[g];
            assign nx_sticky[g] = src_sticky[g];
        end else begin : g_out
            assign nx_data[g]   = g_lvl[CNT-1].sh;
            assign nx_sticky[g] = g_lvl[CNT-1].sout;
        end
    end

    // Stage payload registers; loaded whenever the stage can accept, never reset.
    always_ff @(posedge clk) begin
        for (int g = 0; g < int'(P); g++) begin
            if (can_load[g]) begin
                st_data[g]   <= nx_data[g];
                st_sticky[g] <= nx_sticky[g];
                st_amt[g]    <= src_amt[g];
                st_op[g]     <= src_op[g];
                st_hold[g]   <= src_hold[g];
            end
        end
    end

    // Stage valid bits: flush kills everything, otherwise advance or hold.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st_valid <= '0;
        end else if (flush) begin
            st_valid <= '0;
        end else begin
            st_valid <= (can_load & valid_src) | (~can_load & st_valid);
        end
    end

    assign ready_in   = can_load[0] | flush;
    assign valid_out  = st_valid[P-1];
    assign data_out   = st_data[P-1];
    assign sticky_out = st_sticky[P-1];

endmodule
